// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: parametrised simple-dual-port synchronous RAM with a
// registered read port, selectable read-during-write behaviour and a
// hardware clear sequencer that sweeps every word to INIT_VAL after reset
// or on a clr request.
//
// Optional build macro: RAM_SDP_PARITY_EN
//   defined   -> each word carries an extra even-parity bit, inj_par flips
//                it on a write, par_err reports a mismatch on reads.
//   undefined -> plain DATA_W-bit array, inj_par ignored, par_err tied 0.
//
// Port timing: rvalid is a one-cycle strobe with no back-pressure. It is 1
// in the cycle after an accepted read (re=1 in RUN with clr=0) and marks
// that rdata (and par_err) were updated by that edge; otherwise rvalid=0
// and rdata holds its last value. Writes and reads are accepted only while
// busy=0, and a write or read sampled together with clr is dropped.
//
// The controller state is held in 'state' (ST_CLEAR / ST_RUN) alongside
// the sweep counter 'cnt' so both can be probed directly.

module ram_sdp_clr #(
    parameter int                DATA_W   = 4,
    parameter int                ADDR_W   = 2,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              clr,
    output logic              busy,
    input  logic              inj_par,
    output logic              par_err
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

`ifdef RAM_SDP_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // Controller state
    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              busy_nxt;

    // Storage array; contents are never reset, the sweep initialises them
    logic [MEM_W-1:0]  mem [DEPTH];

    // Access qualification
    logic              run;
    logic              acc_ok;
    logic              wr_user;
    logic              rd_en;

    // Physical write port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;

    // Encoded words and read-port result
    logic [MEM_W-1:0]  init_word;
    logic [MEM_W-1:0]  user_word;
    logic [MEM_W-1:0]  rd_word;
    logic              same_addr;

    assign run     = (state == ST_RUN);
    // A clr request takes priority over any access sampled in the same cycle
    assign acc_ok  = run && !clr;
    assign wr_user = acc_ok && we;
    assign rd_en   = acc_ok && re;

`ifdef RAM_SDP_PARITY_EN
    // Stored parity bit makes the whole word XOR to 0; inj_par corrupts it
    assign init_word = {^INIT_VAL, INIT_VAL};
    assign user_word = {(^wdata) ^ inj_par, wdata};
`else
    logic unused_inj_par;
    assign init_word      = INIT_VAL;
    assign user_word      = wdata;
    assign unused_inj_par = inj_par;
`endif

    // Write port is owned by the sweep while clearing, by the user in RUN
    assign mem_we    = !run || wr_user;
    assign mem_waddr = run ? waddr : cnt;
    assign mem_wdata = run ? user_word : init_word;

    // Write-first forwards the incoming word on a same-address collision;
    // read-first simply samples the array before the write lands.
    assign same_addr = wr_user && (waddr == raddr);
    assign rd_word   = ((RDW_MODE != 0) && same_addr) ? user_word : mem[raddr];

    // Next-state logic for the clear sequencer
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        case (state)
            ST_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
    end

    // Controller registers; reset restarts the sweep from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
        end
    end

    // Array write port (sweep or user), no reset on storage
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port: rdata updates only on an accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef RAM_SDP_PARITY_EN
    logic par_q;

    // Parity check result registered alongside rdata, only with rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= rd_en && (^rd_word);
        end
    end

    assign par_err = par_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed bench for ram_sdp_clr: a read-first instance (dut) and a
// write-first instance (dut_wf) share all inputs.

module tb_ram_sdp_clr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [1:0] waddr = '0;
    logic [3:0] wdata = '0;
    logic       re = 1'b0;
    logic [1:0] raddr = '0;
    logic       clr = 1'b0;
    logic       inj_par = 1'b0;

    logic [3:0] rdata, rdata_wf;
    logic       rvalid, rvalid_wf;
    logic       busy, busy_wf;
    logic       par_err, par_err_wf;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RAM_SDP_PARITY_EN
    logic exp_par_inj = 1'b1;
`else
    logic exp_par_inj = 1'b0;
`endif

    ram_sdp_clr #(.DATA_W(4), .ADDR_W(2), .RDW_MODE(0), .INIT_VAL(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .clr(clr),
        .busy(busy), .inj_par(inj_par), .par_err(par_err)
    );

    ram_sdp_clr #(.DATA_W(4), .ADDR_W(2), .RDW_MODE(1), .INIT_VAL(4'd0)) dut_wf (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_wf), .rvalid(rvalid_wf), .clr(clr),
        .busy(busy_wf), .inj_par(inj_par), .par_err(par_err_wf)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; clr = 1'b0; inj_par = 1'b0;
    endtask

    task automatic fill(input logic [3:0] val);
        for (int a = 0; a < 4; a++) begin
            we = 1'b1; waddr = 2'(a); wdata = val;
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; idle();
        tick(); tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
        n_tests++; if (rdata !== 4'd0) begin n_fail++; $display("FAIL rst_rdata: got %0d want 0", rdata); end
        n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL rst_par_err: got %b want 0", par_err); end
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin tick(); n++; end
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL rst_busy_edges: got %0d want 4", n); end
        for (int a = 0; a < 4; a++) begin
            re = 1'b1; raddr = 2'(a);
            tick();
            n_tests++; if (rvalid !== 1'b1 || rdata !== 4'd0) begin n_fail++; $display("FAIL rst_read%0d: got rvalid=%b rdata=%0d want 1/0", a, rvalid, rdata); end
        end
        re = 1'b0;
        tick();
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_read_idle_rvalid: got %b want 0", rvalid); end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 2'd0; wdata = 4'd10;
        tick();
        we = 1'b0; re = 1'b1; raddr = 2'd0;
        tick();
        n_tests++; if (rvalid !== 1'b1 || rdata !== 4'd10) begin n_fail++; $display("FAIL wr_rd: got rvalid=%b rdata=%0d want 1/10", rvalid, rdata); end
        re = 1'b0;
        tick();
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_idle_rvalid: got %b want 0", rvalid); end
        n_tests++; if (rdata !== 4'd10) begin n_fail++; $display("FAIL wr_rd_hold: got %0d want 10", rdata); end
    endtask

    task automatic test_rdw();
        we = 1'b1; waddr = 2'd1; wdata = 4'd3;
        tick();
        wdata = 4'd9; re = 1'b1; raddr = 2'd1;
        tick();
        n_tests++; if (rdata !== 4'd3) begin n_fail++; $display("FAIL rdw_read_first: got %0d want 3", rdata); end
        n_tests++; if (rdata_wf !== 4'd9) begin n_fail++; $display("FAIL rdw_write_first: got %0d want 9", rdata_wf); end
        n_tests++; if (rvalid !== 1'b1 || rvalid_wf !== 1'b1) begin n_fail++; $display("FAIL rdw_rvalid: got %b/%b want 1/1", rvalid, rvalid_wf); end
        we = 1'b0;
        tick();
        n_tests++; if (rdata !== 4'd9 || rdata_wf !== 4'd9) begin n_fail++; $display("FAIL rdw_after: got %0d/%0d want 9/9", rdata, rdata_wf); end
        // Different addresses in the same cycle are independent
        we = 1'b1; waddr = 2'd2; wdata = 4'd12; raddr = 2'd0;
        tick();
        n_tests++; if (rdata !== 4'd10 || rdata_wf !== 4'd10) begin n_fail++; $display("FAIL rdw_diff_addr: got %0d/%0d want 10/10", rdata, rdata_wf); end
        we = 1'b0; raddr = 2'd2;
        tick();
        n_tests++; if (rdata !== 4'd12 || rdata_wf !== 4'd12) begin n_fail++; $display("FAIL rdw_diff_written: got %0d/%0d want 12/12", rdata, rdata_wf); end
        idle();
        tick();
    endtask

    task automatic test_clear();
        int n;
        fill(4'd5);
        clr = 1'b1; re = 1'b1; raddr = 2'd0;
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b want 1", busy); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL clr_re_dropped: got rvalid=%b want 0", rvalid); end
        clr = 1'b0; re = 1'b1; raddr = 2'd1;
        we = 1'b1; waddr = 2'd2; wdata = 4'd7;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n_tests++; if (rvalid !== 1'b0 || rdata !== 4'd12) begin n_fail++; $display("FAIL clr_busy_hold: got rvalid=%b rdata=%0d want 0/12", rvalid, rdata); end
            n++;
            tick();
        end
        idle();
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d want 4", n); end
        for (int a = 0; a < 4; a++) begin
            re = 1'b1; raddr = 2'(a);
            tick();
            n_tests++; if (rvalid !== 1'b1 || rdata !== 4'd0 || rdata_wf !== 4'd0) begin n_fail++; $display("FAIL clr_read%0d: got rvalid=%b rdata=%0d/%0d want 1/0/0", a, rvalid, rdata, rdata_wf); end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        fill(4'd9);
        re = 1'b1; raddr = 2'd3;
        tick();
        n_tests++; if (rdata !== 4'd9) begin n_fail++; $display("FAIL mid_prefill: got %0d want 9", rdata); end
        re = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b1 || rvalid !== 1'b0 || rdata !== 4'd0) begin n_fail++; $display("FAIL mid_rst_async: got busy=%b rvalid=%b rdata=%0d want 1/0/0", busy, rvalid, rdata); end
        tick();
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin tick(); n++; end
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL mid_busy_edges: got %0d want 4", n); end
        for (int a = 0; a < 4; a++) begin
            re = 1'b1; raddr = 2'(a);
            tick();
            n_tests++; if (rvalid !== 1'b1 || rdata !== 4'd0) begin n_fail++; $display("FAIL mid_read%0d: got rvalid=%b rdata=%0d want 1/0", a, rvalid, rdata); end
        end
        idle();
        tick();
    endtask

    task automatic test_parity();
        we = 1'b1; waddr = 2'd3; wdata = 4'd6; inj_par = 1'b1;
        tick();
        idle(); re = 1'b1; raddr = 2'd3;
        tick();
        n_tests++; if (rvalid !== 1'b1 || rdata !== 4'd6) begin n_fail++; $display("FAIL par_inj_read: got rvalid=%b rdata=%0d want 1/6", rvalid, rdata); end
        n_tests++; if (par_err !== exp_par_inj) begin n_fail++; $display("FAIL par_inj_err: got %b want %b", par_err, exp_par_inj); end
        re = 1'b0;
        tick();
        n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_idle: got %b want 0", par_err); end
        we = 1'b1; waddr = 2'd3; wdata = 4'd6; inj_par = 1'b0;
        tick();
        idle(); re = 1'b1; raddr = 2'd3;
        tick();
        n_tests++; if (par_err !== 1'b0 || rdata !== 4'd6) begin n_fail++; $display("FAIL par_clean: got par_err=%b rdata=%0d want 0/6", par_err, rdata); end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rdw();
        test_clear();
        test_reset_mid_sweep();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM; successor to the fixed 4x4 single-port RAM.
- Adds independent read/write ports, a registered read with a valid strobe, and a selectable read-during-write mode.
- Adds a hardware clear sequencer that sweeps every word to INIT_VAL after reset or on request.
- Used as the generic storage element for vending-machine item tables and credit logs.

Parameters:
- DATA_W, 4, word width in bits (>=1)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words
- RDW_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sweep

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re  in  1  read enable
- raddr  in  ADDR_W  read address
- rdata  out  DATA_W  registered read data
- rvalid  out  1  one-cycle strobe, rdata updated this cycle
- clr  in  1  single-cycle request to restart the clear sweep
- busy  out  1  high while the clear sweep runs
- inj_par  in  1  parity-error injection on write (used only with the optional feature)
- par_err  out  1  parity mismatch on the current read (optional feature)

Behaviour:
- Clock and reset fixed: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rdata=0, rvalid=0, par_err=0, busy=1, FSM=CLEAR, sweep counter=0. Array contents are not reset directly.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Each cycle writes INIT_VAL to mem[cnt]; cnt increments.
  - On the cycle writing DEPTH-1, next state is RUN. busy is registered and falls on the edge that enters RUN.
  - After rst_n rises, busy stays high for exactly DEPTH rising edges.
- While busy:
  - we, re and clr are ignored; rvalid=0.
  - rdata holds its value (0 after reset).
- RUN, write: we=1 writes wdata to mem[waddr] at the edge.
- RUN, read:
  - re=1 at edge N gives rdata=mem[raddr] and rvalid=1 after edge N; latency 1.
  - re=0 drops rvalid to 0 and holds rdata.
- Same-address read and write in the same cycle: RDW_MODE=0 returns the pre-write contents; RDW_MODE=1 returns wdata.
- Different-address read and write in the same cycle are independent.
- clr=1 in RUN:
  - Next state is CLEAR with cnt=0; busy=1 from the next edge.
  - A we or re sampled in the same cycle as clr is dropped.
- Asserting rst_n mid-sweep aborts the sweep. After release the sweep restarts at address 0.
- Address wrap: cnt is ADDR_W bits and compares against DEPTH-1; no overflow bit is needed. All addresses are always in range.

Optional Feature:
- Macro: RAM_SDP_PARITY_EN.
- Defined:
  - The array is DATA_W+1 bits wide. The extra bit stores even parity, XOR of wdata, inverted when inj_par=1 on that write.
  - The clear sweep stores correct parity for INIT_VAL.
  - par_err is registered alongside rdata. It is 1 with rvalid when the stored parity mismatches the stored data; otherwise 0.
  - The read-during-write mode applies to the parity bit identically.
- Undefined:
  - The array is DATA_W bits, inj_par is ignored, and par_err is tied to 0.
  - Ports stay identical so benches are unchanged.

Test Plan:
1. Defaults, rst_n low 2 cycles then high:
   - busy=1 for exactly 4 edges, then 0.
   - Read addresses 0..3 -> rdata=0 each, rvalid high one cycle after each re.
2. Write 10 to addr 0, then re with raddr=0 next cycle -> rdata=10, rvalid=1 one cycle later. rvalid=0 and rdata still 10 in the following idle cycle.
3. Preload addr 1=3, then we=1 wdata=9 waddr=1 with re=1 raddr=1 in the same cycle:
   - RDW_MODE=0 -> rdata=3.
   - RDW_MODE=1 -> rdata=9.
   - A subsequent read returns 9 in both modes.
4. Fill addresses 0..3 with 5, pulse clr:
   - busy high 4 cycles.
   - we=1 wdata=7 waddr=2 issued during busy is ignored.
   - After busy falls, all reads return 0 (INIT_VAL).
5. Assert rst_n low at sweep cycle 2, release -> busy high for a full 4 edges again; reads return 0.
6. With RAM_SDP_PARITY_EN:
   - Write 6 with inj_par=1 to addr 3, read -> par_err=1 with rvalid.
   - Write 6 with inj_par=0, read -> par_err=0.
   - Without the macro, par_err stays 0 throughout.
